// File: rtl/usrt_pkg.sv
// usrt_pkg: parity mode constants, receiver FSM states and the parity helper shared by the USRT blocks
package usrt_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PARITY, S_STOP, S_BREAK} usrt_rx_state_t;
  function automatic logic usrt_parity(input logic [8:0] data, input int mode);
    return mode == PAR_ODD ? ~^data : ^data;
  endfunction
endpackage

// File: rtl/usrt_rx_hold.sv
// usrt_rx_hold: single-entry valid/ready word holder; clk, rst, load/data in, ready in, valid/q/overrun out
module usrt_rx_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] q,
  output logic         overrun
);
  always_ff @(posedge clk)
    if (rst) begin
      valid   <= 1'b0;
      q       <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= load & valid & ~ready;
      valid   <= load | (valid & ~ready);
      if (load & (~valid | ready)) q <= data;
    end
endmodule

// File: rtl/usrt_rx_frame.sv
// usrt_rx_frame: bit-enabled start/data/parity/stop deserialiser; i_Bit_En/i_Rx_Serial/i_Rx_Ready in, word + DV + error pulses out
module usrt_rx_frame
  import usrt_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int LSB_FIRST   = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Bit_En,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun
);
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD ||
      (STOP_BITS != 1 && STOP_BITS != 2) || (LSB_FIRST != 0 && LSB_FIRST != 1)) begin : g_bad_params
    $error("usrt_rx_frame: illegal parameter combination");
  end
  usrt_rx_state_t state, next;
  logic [3:0] bit_cnt;
  logic stop_cnt;
  logic par_err;
  logic [DATA_BITS-1:0] shreg;
  logic deliver, perr, ferr;
  always_comb begin
    next    = state;
    deliver = 1'b0;
    perr    = 1'b0;
    ferr    = 1'b0;
    if (i_Bit_En)
      case (state)
        S_IDLE:   next = i_Rx_Serial ? S_IDLE : S_DATA;
        S_DATA:   next = bit_cnt != 4'(DATA_BITS - 1) ? S_DATA : PARITY_MODE != PAR_NONE ? S_PARITY : S_STOP;
        S_PARITY: next = S_STOP;
        S_STOP:
          if (!i_Rx_Serial) begin
            ferr = 1'b1;
            next = S_BREAK;
          end else if (stop_cnt == 1'(STOP_BITS - 1)) begin
            perr    = par_err;
            deliver = ~par_err;
            next    = S_IDLE;
          end
        S_BREAK:  next = i_Rx_Serial ? S_IDLE : S_BREAK;
        default:  next = S_IDLE;
      endcase
  end
  // The assembly register shifts toward the first-bit end so the word is in place after the last data bit.
  always_ff @(posedge i_Clock)
    if (i_Reset) begin
      state        <= S_IDLE;
      bit_cnt      <= '0;
      stop_cnt     <= 1'b0;
      par_err      <= 1'b0;
      shreg        <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
    end else begin
      state        <= next;
      o_Parity_Err <= perr;
      o_Frame_Err  <= ferr;
      if (i_Bit_En) begin
        bit_cnt  <= state == S_DATA && next == S_DATA ? bit_cnt + 4'd1 : '0;
        stop_cnt <= state == S_STOP && next == S_STOP ? stop_cnt + 1'b1 : 1'b0;
        par_err  <= state == S_PARITY ? i_Rx_Serial != usrt_parity(9'(shreg), PARITY_MODE) :
                    state == S_IDLE ? 1'b0 : par_err;
        if (state == S_DATA)
          shreg <= LSB_FIRST != 0 ? {i_Rx_Serial, shreg[DATA_BITS-1:1]} : {shreg[DATA_BITS-2:0], i_Rx_Serial};
      end
    end
  usrt_rx_hold #(.W(DATA_BITS)) u_hold (
    .clk     (i_Clock),
    .rst     (i_Reset),
    .load    (deliver),
    .data    (shreg),
    .ready   (i_Rx_Ready),
    .valid   (o_Rx_DV),
    .q       (o_Rx_Data),
    .overrun (o_Overrun)
  );
endmodule

// File: tb/tb_usrt_rx_frame.sv
// tb_usrt_rx_frame: five receiver configurations driven by frame-level tasks against a transaction model
module tb_usrt_rx_frame;
  localparam logic [4:0][3:0] DB  = {4'd9, 4'd7, 4'd8, 4'd8, 4'd8};
  localparam logic [4:0][1:0] PM  = {2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
  localparam logic [4:0][1:0] SB  = {2'd2, 2'd1, 2'd2, 2'd1, 2'd1};
  localparam logic [4:0]      LS  = 5'b00111;
  localparam logic [4:0][2:0] PER = {3'd2, 3'd4, 3'd1, 3'd1, 3'd1};
  logic clk = 1'b0;
  logic rst[5], en[5], rx[5], rdy[5], dv[5], pe[5], fe[5], ov[5];
  logic [8:0] dat[5];
  int n_chk = 0, n_err = 0;
  int edv[5], edata[5];
  bit del, xpe, xfe, xov;
  int nd;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    logic [int'(DB[g])-1:0] d;
    usrt_rx_frame #(
      .DATA_BITS(int'(DB[g])), .PARITY_MODE(int'(PM[g])), .STOP_BITS(int'(SB[g])), .LSB_FIRST(int'(LS[g]))
    ) u_dut (
      .i_Clock(clk), .i_Reset(rst[g]), .i_Bit_En(en[g]), .i_Rx_Serial(rx[g]), .i_Rx_Ready(rdy[g]),
      .o_Rx_DV(dv[g]), .o_Rx_Data(d), .o_Parity_Err(pe[g]), .o_Frame_Err(fe[g]), .o_Overrun(ov[g])
    );
    assign dat[g] = 9'(d);
  end
  task automatic chk(string nm, int k, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask
  // One clock: drive inputs, predict the holder outcome, then compare all outputs half a cycle later.
  task automatic tick(int k, bit e, bit v, bit r = 0);
    en[k] = e;
    rx[k] = v;
    rst[k] = r;
    xov = 0;
    if (r) begin
      edv[k] = 0;
      edata[k] = 0;
      xpe = 0;
      xfe = 0;
    end else if (del) begin
      if (edv[k] != 0 && rdy[k]) edata[k] = nd;
      else if (edv[k] != 0) xov = 1;
      else begin
        edv[k] = 1;
        edata[k] = nd;
      end
    end else if (edv[k] != 0 && rdy[k]) edv[k] = 0;
    @(negedge clk);
    chk("dv", k, int'(dv[k]), edv[k]);
    chk("data", k, int'(dat[k]), edata[k]);
    chk("parity_err", k, int'(pe[k]), int'(xpe));
    chk("frame_err", k, int'(fe[k]), int'(xfe));
    chk("overrun", k, int'(ov[k]), int'(xov));
    del = 0;
    xpe = 0;
    xfe = 0;
    rst[k] = 0;
    en[k] = 0;
  endtask
  // One line bit: idle clocks carry random line noise, then the enable clock carries the bit.
  task automatic bitx(int k, bit v, bit dl = 0, bit ep = 0, bit ef = 0, bit rl = 0);
    for (int i = 1; i < int'(PER[k]); i++) tick(k, 0, 1'($urandom_range(0, 1)));
    rdy[k] = rl;
    del = dl;
    xpe = ep;
    xfe = ef;
    tick(k, 1, v);
    rdy[k] = 0;
  endtask
  task automatic frame(int k, int d, bit bp, int bs, bit rl, int idle, int err);
    int db, dm, n;
    bit p;
    db = int'(DB[k]);
    dm = d & ((1 << db) - 1);
    n = bs >= 0 ? bs + 1 : int'(SB[k]);
    nd = dm;
    bitx(k, 0);
    for (int i = 0; i < db; i++) bitx(k, LS[k] ? dm[i] : dm[db-1-i]);
    if (PM[k] != 0) begin
      p = ($countones(dm) % 2 == 1) ^ (PM[k] == 2) ^ bp;
      bitx(k, p);
    end
    for (int s = 0; s < n; s++)
      if (s == n - 1) bitx(k, s != bs, err == 0, err == 1, err == 2, rl);
      else bitx(k, 1);
    repeat (idle) bitx(k, 1);
  endtask
  task automatic pop(int k);
    rdy[k] = 1;
    tick(k, 0, 1);
    rdy[k] = 0;
  endtask
  typedef struct {
    int k; int d; bit bp; int bs; bit rl; int idle; bit pop; int err; int xdv; int xw;
  } vec_t;
  vec_t tbl[15];
  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int ks[3], k, d, bs, err;
    bit bp;
    ks = '{0, 1, 4};
    tbl = '{
      '{0, 'hA5, 0, -1, 0, 0, 1, 0, 1, 'hA5},
      '{0, 'h11, 0, -1, 0, 0, 0, 0, 1, 'h11},
      '{0, 'h22, 0, -1, 0, 0, 0, 0, 1, 'h11},
      '{0, 'h22, 0, -1, 1, 0, 1, 0, 1, 'h22},
      '{1, 'h03, 1, -1, 0, 0, 0, 1, 0, 'h00},
      '{1, 'h03, 0, -1, 0, 0, 1, 0, 1, 'h03},
      '{1, 'hC6, 0,  0, 0, 1, 0, 2, 0, 'h03},
      '{1, 'hC6, 0, -1, 0, 0, 0, 0, 1, 'hC6},
      '{1, 'h3C, 1,  0, 0, 1, 1, 2, 1, 'hC6},
      '{3, 'h41, 0, -1, 0, 0, 1, 0, 1, 'h41},
      '{3, 'h2A, 0, -1, 0, 0, 0, 0, 1, 'h2A},
      '{4, 'h1A5, 0, -1, 0, 0, 1, 0, 1, 'h1A5},
      '{4, 'h0F0, 1, -1, 0, 0, 0, 1, 0, 'h1A5},
      '{4, 'h0F0, 0,  1, 0, 2, 0, 2, 0, 'h1A5},
      '{4, 'h0F0, 0, -1, 0, 0, 0, 0, 1, 'h0F0}
    };
    for (int i = 0; i < 5; i++) begin
      rst[i] = 1;
      en[i] = 0;
      rx[i] = 1;
      rdy[i] = 0;
      edv[i] = 0;
      edata[i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("reset_dv", i, int'(dv[i]), 0);
      chk("reset_data", i, int'(dat[i]), 0);
      chk("reset_errs", i, int'({pe[i], fe[i], ov[i]}), 0);
      rst[i] = 0;
    end
    for (int i = 0; i < 15; i++) begin
      frame(tbl[i].k, tbl[i].d, tbl[i].bp, tbl[i].bs, tbl[i].rl, tbl[i].idle, tbl[i].err);
      chk("tbl_dv", tbl[i].k, int'(dv[tbl[i].k]), tbl[i].xdv);
      chk("tbl_word", tbl[i].k, int'(dat[tbl[i].k]), tbl[i].xw);
      if (tbl[i].pop) pop(tbl[i].k);
    end
    frame(2, 'h5A, 0, 1, 0, 0, 2);
    repeat (20) bitx(2, 0);
    bitx(2, 1);
    frame(2, 'h5A, 0, -1, 0, 0, 0);
    chk("break_recover", 2, int'(dat[2]), 'h5A);
    frame(0, 'h77, 0, -1, 0, 0, 0);
    chk("pre_reset_dv", 0, int'(dv[0]), 1);
    bitx(0, 0);
    for (int i = 0; i < 4; i++) bitx(0, 1);
    tick(0, 1, 1, 1);
    chk("mid_reset_dv", 0, int'(dv[0]), 0);
    frame(0, 'hC3, 0, -1, 0, 0, 0);
    chk("post_reset_word", 0, int'(dat[0]), 'hC3);
    pop(0);
    for (int t = 0; t < 60; t++) begin
      k = ks[$urandom_range(0, 2)];
      d = int'($urandom);
      bp = PM[k] != 0 && $urandom_range(0, 3) == 0;
      bs = $urandom_range(0, 7) == 0 ? int'($urandom_range(0, int'(SB[k]) - 1)) : -1;
      err = bs >= 0 ? 2 : bp ? 1 : 0;
      frame(k, d, bp, bs, 1'($urandom_range(0, 1)), bs >= 0 ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2)), err);
      if ($urandom_range(0, 1) == 1) pop(k);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/usrt_rx_frame.md
# usrt_rx_frame

Parametrised synchronous serial receiver: deserialises start / data / optional parity / stop frames from a bit-synchronous line into parallel words. It checks parity and framing and holds each accepted word under a valid/ready handshake with overrun detection. It sits between the serial pin logic and the byte-consuming datapath. It runs in the system clock domain, advancing only on cycles flagged by a bit-enable strobe.

## Interface
- `DATA_BITS`, 8: data bits per frame, legal 5..9.
- `PARITY_MODE`, 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `LSB_FIRST`, 1: 1 means the first data bit is bit 0; 0 means the first data bit is bit `DATA_BITS-1`.

- `i_Clock`  in  1  sole clock; all logic on rising edge.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Bit_En`  in  1  bit strobe; line sampled and FSM advanced only when 1.
- `i_Rx_Serial`  in  1  serial line, idle high, already synchronous to `i_Clock`.
- `i_Rx_Ready`  in  1  consumer accepts the held word.
- `o_Rx_DV`  out  1  held word valid; level, not pulse.
- `o_Rx_Data`  out  `DATA_BITS`  held word.
- `o_Parity_Err`  out  1  one-cycle pulse, frame discarded.
- `o_Frame_Err`  out  1  one-cycle pulse, stop bit sampled 0, frame discarded.
- `o_Overrun`  out  1  one-cycle pulse, good frame dropped because the holder was full.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP, BREAK. The FSM changes state only on `i_Bit_En=1` cycles.
- **IDLE**
  - bit counter held at 0.
  - line 0 → DATA.
- **DATA**
  - each enable samples one bit into the shift/assembly register at the index set by `LSB_FIRST`.
  - after sample number `DATA_BITS`: → PARITY if `PARITY_MODE≠0`, else → STOP.
- **PARITY**
  - sample p; error when (XOR of data ^ p) is 1 (even) or 0 (odd).
  - error recorded internally; → STOP in both cases.
- **STOP**
  - each enable samples one stop bit; stop counter runs to `STOP_BITS`.
  - any stop sample 0 → `o_Frame_Err` pulse, → BREAK.
  - after the last stop sample is 1:
    - parity error recorded → `o_Parity_Err` pulse, frame discarded.
    - otherwise deliver the frame (see Holder).
    - → IDLE in both cases.
- **BREAK**
  - waits for a sampled 1 on an enable cycle, then → IDLE.
  - no new frame starts while the line stays low.
- **Holder**
  - empty at delivery → load `o_Rx_Data`, set `o_Rx_DV`.
  - full at delivery and `i_Rx_Ready=0` → keep the old word, `o_Overrun` pulse.
  - full at delivery with `i_Rx_Ready=1` in the same cycle → consume the old word and load the new one; `o_Rx_DV` stays 1; no overrun.
  - `o_Rx_DV` & `i_Rx_Ready` with no delivery → `o_Rx_DV` clears next cycle.
- Error outputs are mutually exclusive per frame.
- `i_Rx_Ready` is ignored while `o_Rx_DV=0`.

## Timing
- All outputs are registered.
- Reset values: `o_Rx_DV=0`, `o_Rx_Data=0`, all error pulses 0, FSM=IDLE, counters 0.
- Reset mid-frame discards the partial frame. The first start bit can be detected on the first enable cycle after reset deasserts.
- `o_Rx_DV` and the error pulses assert on the clock edge after the enable cycle that samples the final stop bit. Latency from the start-bit enable to `o_Rx_DV` = `1+DATA_BITS+(PARITY_MODE≠0)+STOP_BITS` enable cycles, plus one clock.
- Minimum frame spacing:
  - back-to-back frames legal; the start bit may be sampled on the enable immediately after the last stop bit.
  - with `i_Bit_En` tied high, one bit per clock.
- Handshake transfer occurs on any rising edge with `o_Rx_DV & i_Rx_Ready`.
- `o_Rx_Data` is stable while `o_Rx_DV=1` and no transfer has occurred.

## Structure
- Shared package `usrt_pkg`:
  - parity mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`.
  - FSM state enum `usrt_rx_state_t`.
  - function `usrt_parity(data, mode)`, reused by the future transmitter.
- One sub-module `usrt_rx_hold`: single-entry valid/ready holding register with overrun pulse generation.
- FSM, counters and assembly register stay in `usrt_rx_frame`.
- Elaboration-time check on parameter legality.

## Test plan
- Defaults, `i_Bit_En=1`, `i_Rx_Ready=0`, line 0 then bits 1,0,1,0,0,1,0,1 then 1 → `o_Rx_Data=8'hA5`, `o_Rx_DV=1` on the clock after the stop sample, held until ready pulsed, then 0.
- `PARITY_MODE=1`, send 8'h03 with parity 1 → `o_Parity_Err` pulse, `o_Rx_DV` stays 0. Resend with parity 0 → `o_Rx_Data=8'h03`.
- `STOP_BITS=2`, second stop sampled 0 → `o_Frame_Err` one pulse. Line held 0 for 20 enables → no further frames. Line 1 then frame 8'h5A → 8'h5A delivered.
- Two back-to-back frames 8'h11, 8'h22 with ready low → first held, `o_Overrun` pulse, data still 8'h11. Repeat with ready high at the second delivery → data 8'h22, no overrun.
- `i_Bit_En` every 4th clock, `DATA_BITS=7`, `LSB_FIRST=0`, value 7'h41 → `o_Rx_Data=7'h41`; the FSM does not advance on non-enable cycles.
- `i_Reset` asserted at data bit 4 → all outputs 0 next cycle. The following full frame 8'hC3 is received correctly.
